// File: rtl/l15_noc_arbiter_if.sv
// NoC1/NoC3 arbitration bundle between the two L1.5 caches, the memory response
// source and the L2 inputs. The slave modport is the arbiter; master is the environment.
interface l15_noc_arbiter_if #(
  parameter int MSG_WIDTH  = 8,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 8,
  parameter int OWNER_BITS = 2
);
  // Handshake: an input is valid when its type != EMPTY; it must hold its fields
  // stable until it sees its ready high, and that cycle is the transfer. The L2
  // consumes msg*_ on any cycle where msg*_ready is high and msg*_type != EMPTY.
  logic [MSG_WIDTH-1:0]  c0_msg1_type, c1_msg1_type, c0_msg3_type, c1_msg3_type, mem_msg3_type;
  logic [DATA_WIDTH-1:0] c0_msg1_data, c1_msg1_data, c0_msg3_data, c1_msg3_data, mem_msg3_data;
  logic [TAG_WIDTH-1:0]  c0_msg1_tag, c1_msg1_tag, c0_msg3_tag, c1_msg3_tag, mem_msg3_tag;
  logic                  c0_msg1_ready, c1_msg1_ready, c0_msg3_ready, c1_msg3_ready, mem_msg3_ready;

  logic [MSG_WIDTH-1:0]  msg1_type, msg3_type;
  logic [DATA_WIDTH-1:0] msg1_data, msg3_data;
  logic [TAG_WIDTH-1:0]  msg1_tag, msg3_tag;
  logic [OWNER_BITS-1:0] msg1_source, msg3_source;
  logic                  msg3_from_mem;
  logic                  msg1_ready, msg3_ready;

  modport slave (
    input  c0_msg1_type, c0_msg1_data, c0_msg1_tag, c1_msg1_type, c1_msg1_data, c1_msg1_tag,
    input  c0_msg3_type, c0_msg3_data, c0_msg3_tag, c1_msg3_type, c1_msg3_data, c1_msg3_tag,
    input  mem_msg3_type, mem_msg3_data, mem_msg3_tag,
    input  msg1_ready, msg3_ready,
    output c0_msg1_ready, c1_msg1_ready, c0_msg3_ready, c1_msg3_ready, mem_msg3_ready,
    output msg1_type, msg1_data, msg1_tag, msg1_source,
    output msg3_type, msg3_data, msg3_tag, msg3_source, msg3_from_mem
  );

  modport master (
    output c0_msg1_type, c0_msg1_data, c0_msg1_tag, c1_msg1_type, c1_msg1_data, c1_msg1_tag,
    output c0_msg3_type, c0_msg3_data, c0_msg3_tag, c1_msg3_type, c1_msg3_data, c1_msg3_tag,
    output mem_msg3_type, mem_msg3_data, mem_msg3_tag,
    output msg1_ready, msg3_ready,
    input  c0_msg1_ready, c1_msg1_ready, c0_msg3_ready, c1_msg3_ready, mem_msg3_ready,
    input  msg1_type, msg1_data, msg1_tag, msg1_source,
    input  msg3_type, msg3_data, msg3_tag, msg3_source, msg3_from_mem
  );
endinterface

// File: rtl/l15_noc_arbiter.sv
// Registered NoC1/NoC3 arbiter: round-robin between the two cores, and on NoC3
// memory responses win unless they have already taken MEM_MAX grants past a waiting core.
module l15_noc_arbiter #(
  parameter int MEM_MAX    = 3,
  parameter int CNT_W      = 2,
  parameter int MSG_WIDTH  = 8,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 8,
  parameter int OWNER_BITS = 2
) (
  input  logic clk,
  input  logic rst,
  l15_noc_arbiter_if.slave bus
);

  localparam logic [MSG_WIDTH-1:0]  MSG_TYPE_EMPTY = '0;
  localparam logic [OWNER_BITS-1:0] SRC_C0 = OWNER_BITS'(0);
  localparam logic [OWNER_BITS-1:0] SRC_C1 = OWNER_BITS'(1);
  localparam logic [CNT_W-1:0]      STREAK_MAX = CNT_W'(MEM_MAX);

  logic c0_v1, c1_v1, c0_v3, c1_v3, mem_v3, core_v3;
  logic free1, free3;
  logic ptr1, ptr3;
  logic [CNT_W-1:0] streak;
  logic g1_c0, g1_c1, g3_c0, g3_c1, g3_mem;

  assign c0_v1   = bus.c0_msg1_type  != MSG_TYPE_EMPTY;
  assign c1_v1   = bus.c1_msg1_type  != MSG_TYPE_EMPTY;
  assign c0_v3   = bus.c0_msg3_type  != MSG_TYPE_EMPTY;
  assign c1_v3   = bus.c1_msg3_type  != MSG_TYPE_EMPTY;
  assign mem_v3  = bus.mem_msg3_type != MSG_TYPE_EMPTY;
  assign core_v3 = c0_v3 | c1_v3;

  // An output register can take a new message if it is empty or being drained now.
  assign free1 = (bus.msg1_type == MSG_TYPE_EMPTY) | bus.msg1_ready;
  assign free3 = (bus.msg3_type == MSG_TYPE_EMPTY) | bus.msg3_ready;

  always_comb begin
    g1_c0  = 1'b0;
    g1_c1  = 1'b0;
    g3_c0  = 1'b0;
    g3_c1  = 1'b0;
    g3_mem = 1'b0;
    if (!rst && free1) begin
      if (c0_v1 && c1_v1) begin
        g1_c0 = ~ptr1;
        g1_c1 = ptr1;
      end else begin
        g1_c0 = c0_v1;
        g1_c1 = c1_v1;
      end
    end
    if (!rst && free3) begin
      if (mem_v3 && !(core_v3 && streak == STREAK_MAX)) begin
        g3_mem = 1'b1;
      end else if (c0_v3 && c1_v3) begin
        g3_c0 = ~ptr3;
        g3_c1 = ptr3;
      end else begin
        g3_c0 = c0_v3;
        g3_c1 = c1_v3;
      end
    end
  end

  assign bus.c0_msg1_ready  = g1_c0;
  assign bus.c1_msg1_ready  = g1_c1;
  assign bus.c0_msg3_ready  = g3_c0;
  assign bus.c1_msg3_ready  = g3_c1;
  assign bus.mem_msg3_ready = g3_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.msg1_type   <= MSG_TYPE_EMPTY;
      bus.msg1_data   <= '0;
      bus.msg1_tag    <= '0;
      bus.msg1_source <= '0;
      ptr1            <= 1'b0;
    end else if (g1_c0) begin
      bus.msg1_type   <= bus.c0_msg1_type;
      bus.msg1_data   <= bus.c0_msg1_data;
      bus.msg1_tag    <= bus.c0_msg1_tag;
      bus.msg1_source <= SRC_C0;
      ptr1            <= 1'b1;
    end else if (g1_c1) begin
      bus.msg1_type   <= bus.c1_msg1_type;
      bus.msg1_data   <= bus.c1_msg1_data;
      bus.msg1_tag    <= bus.c1_msg1_tag;
      bus.msg1_source <= SRC_C1;
      ptr1            <= 1'b0;
    end else if (bus.msg1_ready) begin
      bus.msg1_type   <= MSG_TYPE_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.msg3_type     <= MSG_TYPE_EMPTY;
      bus.msg3_data     <= '0;
      bus.msg3_tag      <= '0;
      bus.msg3_source   <= '0;
      bus.msg3_from_mem <= 1'b0;
      ptr3              <= 1'b0;
    end else if (g3_mem) begin
      bus.msg3_type     <= bus.mem_msg3_type;
      bus.msg3_data     <= bus.mem_msg3_data;
      bus.msg3_tag      <= bus.mem_msg3_tag;
      bus.msg3_source   <= SRC_C0;
      bus.msg3_from_mem <= 1'b1;
    end else if (g3_c0) begin
      bus.msg3_type     <= bus.c0_msg3_type;
      bus.msg3_data     <= bus.c0_msg3_data;
      bus.msg3_tag      <= bus.c0_msg3_tag;
      bus.msg3_source   <= SRC_C0;
      bus.msg3_from_mem <= 1'b0;
      ptr3              <= 1'b1;
    end else if (g3_c1) begin
      bus.msg3_type     <= bus.c1_msg3_type;
      bus.msg3_data     <= bus.c1_msg3_data;
      bus.msg3_tag      <= bus.c1_msg3_tag;
      bus.msg3_source   <= SRC_C1;
      bus.msg3_from_mem <= 1'b0;
      ptr3              <= 1'b0;
    end else if (bus.msg3_ready) begin
      bus.msg3_type     <= MSG_TYPE_EMPTY;
    end
  end

  // The streak only measures how long a waiting core has been passed over.
  always_ff @(posedge clk) begin
    if (rst || g3_c0 || g3_c1 || !core_v3) begin
      streak <= '0;
    end else if (g3_mem && streak != STREAK_MAX) begin
      streak <= streak + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_l15_noc_arbiter.sv
// Directed bench for l15_noc_arbiter: reset, backpressure, NoC1 contention,
// memory grant bound, drain+grant and mid-transfer reset.
module tb_l15_noc_arbiter;

  localparam logic [7:0] T_EMPTY = 8'h00;
  localparam logic [7:0] T_REQ   = 8'h01;
  localparam logic [7:0] T_WB    = 8'h02;
  localparam logic [7:0] T_LMA   = 8'h13;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] mem_seq;

  l15_noc_arbiter_if #(.MSG_WIDTH(8), .DATA_WIDTH(64), .TAG_WIDTH(8), .OWNER_BITS(2)) ifc ();

  l15_noc_arbiter #(.MEM_MAX(3), .CNT_W(2), .MSG_WIDTH(8), .DATA_WIDTH(64),
                    .TAG_WIDTH(8), .OWNER_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mem_seq = 8'b0111_0111;
    ifc.c0_msg1_type = T_EMPTY; ifc.c0_msg1_data = '0; ifc.c0_msg1_tag = '0;
    ifc.c1_msg1_type = T_EMPTY; ifc.c1_msg1_data = '0; ifc.c1_msg1_tag = '0;
    ifc.c0_msg3_type = T_EMPTY; ifc.c0_msg3_data = '0; ifc.c0_msg3_tag = '0;
    ifc.c1_msg3_type = T_EMPTY; ifc.c1_msg3_data = '0; ifc.c1_msg3_tag = '0;
    ifc.mem_msg3_type = T_EMPTY; ifc.mem_msg3_data = '0; ifc.mem_msg3_tag = '0;
    ifc.msg1_ready = 1'b0;
    ifc.msg3_ready = 1'b0;

    // Reset for two cycles with a request already pending on core 0.
    rst = 1'b1;
    ifc.c0_msg1_type = T_REQ; ifc.c0_msg1_tag = 8'h77;
    #1;
    check("rst_c0_rdy1_a", 64'(ifc.c0_msg1_ready), 64'd0);
    tick();
    check("rst_c0_rdy1_b", 64'(ifc.c0_msg1_ready), 64'd0);
    tick();
    check("rst_msg1_type", 64'(ifc.msg1_type), 64'(T_EMPTY));
    check("rst_msg3_type", 64'(ifc.msg3_type), 64'(T_EMPTY));
    check("rst_msg1_src", 64'(ifc.msg1_source), 64'd0);
    check("rst_msg3_mem", 64'(ifc.msg3_from_mem), 64'd0);
    check("rst_msg1_tag", 64'(ifc.msg1_tag), 64'd0);
    rst = 1'b0;
    ifc.c0_msg1_type = T_EMPTY;

    // Backpressure: core 0 tag 5 held while L2 not ready; core 1 waits.
    ifc.c0_msg1_type = T_REQ; ifc.c0_msg1_tag = 8'h05; ifc.c0_msg1_data = 64'h1111;
    #1;
    check("bp_c0_rdy", 64'(ifc.c0_msg1_ready), 64'd1);
    check("bp_c1_rdy_idle", 64'(ifc.c1_msg1_ready), 64'd0);
    tick();
    ifc.c0_msg1_type = T_EMPTY;
    ifc.c1_msg1_type = T_REQ; ifc.c1_msg1_tag = 8'h09; ifc.c1_msg1_data = 64'h2222;
    #1;
    check("bp_tag_0", 64'(ifc.msg1_tag), 64'h05);
    check("bp_type_0", 64'(ifc.msg1_type), 64'(T_REQ));
    check("bp_data_0", ifc.msg1_data, 64'h1111);
    check("bp_src_0", 64'(ifc.msg1_source), 64'd0);
    check("bp_c0_rdy_0", 64'(ifc.c0_msg1_ready), 64'd0);
    check("bp_c1_rdy_0", 64'(ifc.c1_msg1_ready), 64'd0);
    tick();
    check("bp_tag_1", 64'(ifc.msg1_tag), 64'h05);
    check("bp_c1_rdy_1", 64'(ifc.c1_msg1_ready), 64'd0);
    tick();
    check("bp_tag_2", 64'(ifc.msg1_tag), 64'h05);
    check("bp_c1_rdy_2", 64'(ifc.c1_msg1_ready), 64'd0);
    ifc.msg1_ready = 1'b1;
    #1;
    check("bp_release_c1_rdy", 64'(ifc.c1_msg1_ready), 64'd1);
    tick();
    ifc.c1_msg1_type = T_EMPTY;
    check("bp_next_tag", 64'(ifc.msg1_tag), 64'h09);
    check("bp_next_src", 64'(ifc.msg1_source), 64'd1);
    tick();
    check("bp_drain_type", 64'(ifc.msg1_type), 64'(T_EMPTY));
    check("bp_drain_tag_hold", 64'(ifc.msg1_tag), 64'h09);

    // NoC1 contention: pointer last moved to core 0, so grants go 0,1,0,1.
    ifc.c0_msg1_type = T_REQ; ifc.c0_msg1_tag = 8'h10;
    ifc.c1_msg1_type = T_REQ; ifc.c1_msg1_tag = 8'h11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ct_c0_rdy", 64'(ifc.c0_msg1_ready), 64'(i % 2 == 0));
      check("ct_c1_rdy", 64'(ifc.c1_msg1_ready), 64'(i % 2 == 1));
      tick();
      check("ct_src", 64'(ifc.msg1_source), 64'(i % 2));
      check("ct_tag", 64'(ifc.msg1_tag), 64'h10 + 64'(i % 2));
    end
    ifc.c0_msg1_type = T_EMPTY;
    ifc.c1_msg1_type = T_EMPTY;
    tick();
    check("ct_empty", 64'(ifc.msg1_type), 64'(T_EMPTY));

    // Memory bound: memory and core 1 both valid, L2 always ready.
    ifc.mem_msg3_type = T_LMA; ifc.mem_msg3_tag = 8'h20;
    ifc.c1_msg3_type  = T_WB;  ifc.c1_msg3_tag  = 8'h31;
    ifc.msg3_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("mb_mem_rdy", 64'(ifc.mem_msg3_ready), 64'(mem_seq[i]));
      check("mb_c1_rdy", 64'(ifc.c1_msg3_ready), 64'(!mem_seq[i]));
      tick();
      check("mb_from_mem", 64'(ifc.msg3_from_mem), 64'(mem_seq[i]));
      check("mb_src", 64'(ifc.msg3_source), mem_seq[i] ? 64'd0 : 64'd1);
      check("mb_tag", 64'(ifc.msg3_tag), mem_seq[i] ? 64'h20 : 64'h31);
    end
    ifc.mem_msg3_type = T_EMPTY;
    ifc.c1_msg3_type  = T_EMPTY;
    tick();
    check("mb_empty", 64'(ifc.msg3_type), 64'(T_EMPTY));

    // Drain and grant in the same cycle on NoC3.
    ifc.msg3_ready = 1'b0;
    ifc.c0_msg3_type = T_WB; ifc.c0_msg3_tag = 8'h40;
    #1;
    check("dg_c0_rdy", 64'(ifc.c0_msg3_ready), 64'd1);
    tick();
    ifc.c0_msg3_type = T_EMPTY;
    check("dg_hold_tag", 64'(ifc.msg3_tag), 64'h40);
    check("dg_hold_src", 64'(ifc.msg3_source), 64'd0);
    ifc.c1_msg3_type = T_WB; ifc.c1_msg3_tag = 8'h41;
    ifc.msg3_ready = 1'b1;
    #1;
    check("dg_c1_rdy", 64'(ifc.c1_msg3_ready), 64'd1);
    tick();
    ifc.c1_msg3_type = T_EMPTY;
    check("dg_no_bubble", 64'(ifc.msg3_type), 64'(T_WB));
    check("dg_tag", 64'(ifc.msg3_tag), 64'h41);
    check("dg_src", 64'(ifc.msg3_source), 64'd1);
    check("dg_from_mem", 64'(ifc.msg3_from_mem), 64'd0);
    tick();
    check("dg_empty", 64'(ifc.msg3_type), 64'(T_EMPTY));

    // Reset while NoC1 holds a backpressured message; pointer had moved to core 1.
    ifc.msg1_ready = 1'b0;
    ifc.c0_msg1_type = T_REQ; ifc.c0_msg1_tag = 8'h50;
    #1;
    check("rm_c0_rdy", 64'(ifc.c0_msg1_ready), 64'd1);
    tick();
    ifc.c0_msg1_type = T_EMPTY;
    check("rm_held_tag", 64'(ifc.msg1_tag), 64'h50);
    rst = 1'b1;
    ifc.c0_msg1_type = T_REQ; ifc.c0_msg1_tag = 8'h60;
    ifc.c1_msg1_type = T_REQ; ifc.c1_msg1_tag = 8'h61;
    #1;
    check("rm_rst_c0_rdy", 64'(ifc.c0_msg1_ready), 64'd0);
    check("rm_rst_c1_rdy", 64'(ifc.c1_msg1_ready), 64'd0);
    tick();
    rst = 1'b0;
    check("rm_type", 64'(ifc.msg1_type), 64'(T_EMPTY));
    check("rm_tag", 64'(ifc.msg1_tag), 64'd0);
    check("rm_src", 64'(ifc.msg1_source), 64'd0);
    #1;
    check("rm_ptr_c0_rdy", 64'(ifc.c0_msg1_ready), 64'd1);
    check("rm_ptr_c1_rdy", 64'(ifc.c1_msg1_ready), 64'd0);
    tick();
    ifc.c0_msg1_type = T_EMPTY;
    check("rm_first_tag", 64'(ifc.msg1_tag), 64'h60);
    ifc.msg1_ready = 1'b1;
    #1;
    check("rm_c1_rdy", 64'(ifc.c1_msg1_ready), 64'd1);
    tick();
    ifc.c1_msg1_type = T_EMPTY;
    check("rm_second_tag", 64'(ifc.msg1_tag), 64'h61);
    check("rm_second_src", 64'(ifc.msg1_source), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
